traza_puntaje_tx: RTL and testbench

TRAZA_PUNTAJE_TX -- requirements
Module: traza_puntaje_tx

---
 rtl/traza_puntaje_tx.sv | 182 ++++++++++++++++++
 tb/tb_traza_puntaje_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traza_puntaje_tx.sv
// traza_puntaje_tx: score/state trace transmitter.
// Captures every change of {presente, puntos} into a small FIFO and sends each
// record as a 3-byte UART 8N1 frame: A5 sync, {presente, 0000, puntos[8]},
// puntos[7:0].
//
// Handshake: the FIFO is internal. A record is written on any edge where the
// input differs from the previous cycle. It is accepted when the FIFO is not
// full, or when it is full but the transmitter pops at that same edge;
// otherwise it is dropped and desborde is latched. The transmitter pops only
// in IDLE with the FIFO non-empty. Popped records are held in r_reg for the
// whole frame, so later input changes cannot alter a frame already in flight.
module traza_puntaje_tx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] puntos,
   input  logic [2:0] presente,
   output logic       tx,
   output logic       ocupado,
   output logic       desborde
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   PTR_MSB   = {1'b1, {AW{1'b0}}};
   localparam logic [7:0]    SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } estado_t;

   estado_t        r_estado;
   logic [11:0]    r_previo;
   logic [11:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]    r_wptr;
   logic [AW:0]    r_rptr;
   logic           r_desborde;
   logic           r_tx;
   logic [BW-1:0]  r_baud;
   logic [2:0]     r_bit;
   logic [1:0]     r_byte_idx;
   logic [11:0]    r_reg;
   logic [7:0]     r_shift;

   logic [11:0]    w_actual;
   logic           w_cambio;
   logic           w_vacia;
   logic           w_llena;
   logic           w_pop;
   logic           w_push;
   logic [11:0]    w_dato_fifo;
   logic [7:0]     w_sig_byte;

   assign w_actual    = {presente, puntos};
   assign w_cambio    = (w_actual != r_previo);
   assign w_vacia     = (r_wptr == r_rptr);
   assign w_llena     = ((r_wptr ^ r_rptr) == PTR_MSB);
   assign w_pop       = (r_estado == ST_IDLE) && !w_vacia;
   assign w_push      = w_cambio && (!w_llena || w_pop);
   assign w_dato_fifo = r_mem[r_rptr[AW-1:0]];
   // Byte that follows the one just finished: index 0 -> header, 1 -> score low.
   assign w_sig_byte  = (r_byte_idx == 2'd0) ? {r_reg[11:9], 4'b0000, r_reg[8]}
                                             : r_reg[7:0];

   assign tx       = r_tx;
   assign desborde = r_desborde;
   assign ocupado  = (r_estado != ST_IDLE) || !w_vacia;

   // Previous-cycle copy of the inputs, used for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_previo <= 12'h000;
      end else begin
         r_previo <= w_actual;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= w_actual;
      end
   end

   // FIFO pointers and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_desborde <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
         end
         if (w_cambio && w_llena && !w_pop) begin
            r_desborde <= 1'b1;
         end
      end
   end

   // UART transmitter FSM with registered tx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado   <= ST_IDLE;
         r_tx       <= 1'b1;
         r_baud     <= '0;
         r_bit      <= 3'd0;
         r_byte_idx <= 2'd0;
         r_reg      <= 12'h000;
         r_shift    <= 8'h00;
      end else begin
         case (r_estado)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_reg      <= w_dato_fifo;
                  r_shift    <= SYNC_BYTE;
                  r_byte_idx <= 2'd0;
                  r_baud     <= '0;
                  r_tx       <= 1'b0;
                  r_estado   <= ST_START;
               end
            end
            ST_START: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud   <= '0;
                  r_bit    <= 3'd0;
                  r_tx     <= r_shift[0];
                  r_estado <= ST_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_DATA: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx     <= 1'b1;
                     r_estado <= ST_STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[1];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_STOP: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_byte_idx != 2'd2) begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_shift    <= w_sig_byte;
                     r_tx       <= 1'b0;
                     r_estado   <= ST_START;
                  end else begin
                     r_tx     <= 1'b1;
                     r_estado <= ST_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_tx     <= 1'b1;
               r_estado <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traza_puntaje_tx.sv
// Bench for traza_puntaje_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Stimulus pushes expected UART bytes into exp_q; an independent UART
// receiver process pops and compares each received byte.
module tb_traza_puntaje_tx;

   localparam int C = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] puntos = 9'h000;
   logic [2:0] presente = 3'b000;
   logic       tx;
   logic       ocupado;
   logic       desborde;

   int         n_vec = 0;
   int         n_err = 0;
   int         n_rx = 0;
   logic       rst_seen = 1'b0;
   logic       mon_busy = 1'b0;
   logic [7:0] exp_q[$];

   traza_puntaje_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .puntos   (puntos),
      .presente (presente),
      .tx       (tx),
      .ocupado  (ocupado),
      .desborde (desborde)
   );

   // Clock and reset-event tracking.
   always #5 clk = ~clk;
   always @(negedge rst_n) rst_seen = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, expv);
      end
   endtask

   task automatic drive(input logic [2:0] s, input logic [8:0] p);
      @(negedge clk);
      presente = s;
      puntos   = p;
   endtask

   task automatic push_frame(input logic [2:0] s, input logic [8:0] p);
      exp_q.push_back(8'hA5);
      exp_q.push_back({s, 4'b0000, p[8]});
      exp_q.push_back(p[7:0]);
   endtask

   task automatic do_reset(input logic [2:0] s, input logic [8:0] p);
      @(negedge clk);
      rst_n    = 1'b0;
      presente = s;
      puntos   = p;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_ocupado", {31'b0, ocupado}, 32'd0);
      check("rst_desborde", {31'b0, desborde}, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while ((ocupado !== 1'b0 || mon_busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_reached", {31'b0, (k < budget)}, 32'd1);
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   // Monitor: UART receiver sampling mid-bit on falling clock edges.
   initial begin : monitor
      logic [9:0] fr;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            mon_busy = 1'b1;
            rst_seen = 1'b0;
            @(negedge clk);
            fr[0] = tx;
            for (int j = 1; j < 10; j++) begin
               repeat (C) @(negedge clk);
               fr[j] = tx;
            end
            if (!rst_seen) begin
               n_rx++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL uart_byte: got unexpected frame %03h, want none", fr);
               end else begin
                  e = exp_q.pop_front();
                  check("uart_byte", {22'b0, fr}, {22'b0, 1'b1, e, 1'b0});
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int bad;
      int cnt;
      int rx0;

      // Power-on reset, then quiet inputs for 200 cycles.
      repeat (3) @(negedge clk);
      check("por_tx", {31'b0, tx}, 32'd1);
      check("por_ocupado", {31'b0, ocupado}, 32'd0);
      check("por_desborde", {31'b0, desborde}, 32'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || ocupado !== 1'b0) bad++;
      end
      check("idle_hold", bad, 32'd0);

      // Single change: A5 A1 2D, ocupado high for 121 cycles from the change edge.
      push_frame(3'b101, 9'h12D);
      drive(3'b101, 9'h12D);
      cnt = 0;
      for (int m = 0; m < 400; m++) begin
         @(negedge clk);
         if (m == 0) check("tx_before_pop", {31'b0, tx}, 32'd1);
         if (m == 1) check("tx_fall", {31'b0, tx}, 32'd0);
         if (ocupado === 1'b1) cnt++;
         else break;
      end
      check("ocupado_len", cnt, 32'd121);
      check("frame1_drained", exp_q.size(), 32'd0);

      // Nonzero inputs across reset release enqueue one record.
      do_reset(3'b101, 9'h12D);
      push_frame(3'b101, 9'h12D);
      @(negedge clk);
      check("restart_capture", {31'b0, ocupado}, 32'd1);
      wait_idle(400);

      // Six consecutive changes: five frames, one drop.
      do_reset(3'b000, 9'h000);
      drive(3'd1, 9'h001);
      drive(3'd2, 9'h102);
      drive(3'd3, 9'h0F3);
      drive(3'd4, 9'h1AA);
      drive(3'd6, 9'h055);
      push_frame(3'd1, 9'h001);
      push_frame(3'd2, 9'h102);
      push_frame(3'd3, 9'h0F3);
      push_frame(3'd4, 9'h1AA);
      push_frame(3'd6, 9'h055);
      drive(3'd7, 9'h1FF);
      check("desborde_pre", {31'b0, desborde}, 32'd0);
      @(negedge clk);
      check("desborde_set", {31'b0, desborde}, 32'd1);
      wait_idle(1000);
      check("desborde_sticky", {31'b0, desborde}, 32'd1);

      // Change at the very edge the FSM pops from a full FIFO: accepted.
      do_reset(3'b000, 9'h000);
      drive(3'd1, 9'h010);
      drive(3'd2, 9'h020);
      drive(3'd3, 9'h130);
      drive(3'd4, 9'h040);
      drive(3'd5, 9'h150);
      push_frame(3'd1, 9'h010);
      push_frame(3'd2, 9'h020);
      push_frame(3'd3, 9'h130);
      push_frame(3'd4, 9'h040);
      push_frame(3'd5, 9'h150);
      repeat (117) @(negedge clk);
      check("full_before_pop", {31'b0, desborde}, 32'd0);
      drive(3'd6, 9'h066);
      push_frame(3'd6, 9'h066);
      @(negedge clk);
      check("pop_push_nodrop", {31'b0, desborde}, 32'd0);
      wait_idle(1000);
      check("pop_push_final", {31'b0, desborde}, 32'd0);

      // Two queued records: exactly one idle cycle between frames.
      do_reset(3'b000, 9'h000);
      drive(3'd3, 9'h1C4);
      drive(3'd5, 9'h03B);
      push_frame(3'd3, 9'h1C4);
      push_frame(3'd5, 9'h03B);
      repeat (120) @(negedge clk);
      check("stop_byte2", {31'b0, tx}, 32'd1);
      @(negedge clk);
      check("gap_idle", {31'b0, tx}, 32'd1);
      @(negedge clk);
      check("start_frame2", {31'b0, tx}, 32'd0);
      wait_idle(400);

      // Reset mid-byte1: tx high at once, nothing resumes.
      do_reset(3'b000, 9'h000);
      rx0 = n_rx;
      drive(3'd2, 9'h0AB);
      push_frame(3'd2, 9'h0AB);
      repeat (60) @(negedge clk);
      check("byte0_done", n_rx, rx0 + 1);
      check("tx_low_mid", {31'b0, ocupado}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_tx_hi", {31'b0, tx}, 32'd1);
      check("async_ocupado", {31'b0, ocupado}, 32'd0);
      exp_q.delete();
      presente = 3'b000;
      puntos   = 9'h000;
      @(negedge clk);
      rst_n = 1'b1;
      rx0 = n_rx;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || ocupado !== 1'b0) bad++;
      end
      check("no_resume", bad, 32'd0);
      check("no_partial_bytes", n_rx, rx0);
      check("final_queue", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
